mask_prng: RTL

Fresh-randomness source sitting directly upstream of the masker. It produces SHARES-1 independent WIDTH-bit masks per transfer over a valid/ready handshake, built from parallel xorshift64 lanes. It is seeded from an external entropy port, runs a warm-up before emitting, and forces a reseed after a fixed number of transfers.

---
 rtl/mask_pkg.sv | 32 +++
 rtl/xorshift64_lane.sv | 28 ++
 rtl/mask_prng.sv | 107 ++++++++++
 3 files changed

// File: rtl/mask_pkg.sv
// Shared types, constants and helper functions for the mask PRNG.
package mask_pkg;

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARMUP,
    ST_RUN,
    ST_EXHAUSTED
  } state_t;

  // Golden-ratio increment that spreads one seed word across all lanes.
  localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

  // One xorshift64 step with logical shifts (13, 7, 17).
  function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // Seed value for lane i. Zero is a fixed point of xorshift, so it is
  // replaced by 1 to keep every lane on the full-period orbit.
  function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int i);
    logic [63:0] v;
    v = seed + (64'(i + 1) * GOLDEN);
    if (v == 64'h0) v = 64'h1;
    return v;
  endfunction

endpackage

// File: rtl/xorshift64_lane.sv
// Single 64-bit xorshift64 register with synchronous load and step enable.
module xorshift64_lane
  import mask_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic        step,
  output logic [63:0] value
);

  // Lane register: load has priority over step.
  // NOTE: the lane drives m_out directly, so it is reset to a known zero
  // rather than left uninitialised; it is unused until the first seed load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 64'h0;
    end else if (load) begin
      // NOTE: non-blocking assignment so every lane samples the same
      // pre-edge values regardless of evaluation order.
      value <= load_value;
    end else if (step) begin
      value <= xorshift64_step(value);
    end
  end

endmodule

// File: rtl/mask_prng.sv
// Fresh-randomness source: SHARES-1 WIDTH-bit masks per transfer from
// parallel xorshift64 lanes, with seeding, warm-up and forced reseed.
module mask_prng
  import mask_pkg::*;
#(
  parameter int SHARES          = 3,
  parameter int WIDTH           = 256,
  parameter int WARMUP          = 16,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               seed_valid,
  output logic                               seed_ready,
  input  logic [63:0]                        seed,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [WIDTH-1:0]                   m_out [0:SHARES-2],
  output logic                               need_seed,
  output logic [$clog2(RESEED_INTERVAL+1)-1:0] out_count
);

  localparam int NW  = WIDTH / 64;
  localparam int L   = (SHARES - 1) * NW;
  localparam int OCW = $clog2(RESEED_INTERVAL + 1);
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [OCW-1:0] OUT_LAST  = OCW'(RESEED_INTERVAL - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WCW-1:0]   warm_cnt;
  logic             seed_fire;
  logic             m_fire;
  logic             lane_step;
  logic [63:0]      lanes [L];

  // Handshake flags are decoded from the state register only, so no
  // input reaches an output combinationally.
  assign seed_ready = (state == ST_UNSEEDED) || (state == ST_EXHAUSTED);
  assign need_seed  = seed_ready;
  assign m_valid    = (state == ST_RUN);
  assign seed_fire  = seed_valid && seed_ready;
  assign m_fire     = m_valid && m_ready;
  assign lane_step  = (state == ST_WARMUP) || m_fire;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_UNSEEDED;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_UNSEEDED, ST_EXHAUSTED: begin
        if (seed_fire) state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (warm_cnt == WARM_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (m_fire && (out_count == OUT_LAST)) state_nxt = ST_EXHAUSTED;
      end
      default: state_nxt = ST_UNSEEDED;
    endcase
  end

  // Warm-up step counter, restarted by every seed load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  warm_cnt <= '0;
    else if (seed_fire)          warm_cnt <= '0;
    else if (state == ST_WARMUP) warm_cnt <= warm_cnt + 1'b1;
  end

  // Transfers since last seed; holds at RESEED_INTERVAL until reseeded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_count <= '0;
    else if (seed_fire) out_count <= '0;
    else if (m_fire)    out_count <= out_count + 1'b1;
  end

  for (genvar i = 0; i < L; i++) begin : g_lane
    xorshift64_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (seed_fire),
      .load_value (lane_seed(seed, i)),
      .step       (lane_step),
      .value      (lanes[i])
    );
  end

  // Pure wiring of lane registers onto the mask array.
  always_comb begin
    for (int s = 0; s < SHARES - 1; s++) begin
      for (int j = 0; j < NW; j++) begin
        m_out[s][64*j +: 64] = lanes[s*NW + j];
      end
    end
  end

endmodule
